// File: rtl/phase_to_amp.sv
// phase_to_amp: quarter-wave sine lookup scaled by amp, offset added and saturated to a DAC code
module phase_to_amp #(
    parameter int PHASE_BITS = 14,
    parameter int LUT_ADDR_BITS = PHASE_BITS - 2,
    parameter bit OUT_OFFSET_BINARY = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] phase_in,
    input  logic [13:0] amp_in,
    input  logic [15:0] offset_in,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data
);
    localparam int N = 2 ** LUT_ADDR_BITS;

    function automatic logic [14:0] rom_val(int i);
        real x;
        x = 32767.0 * $sin(3.14159265358979323846 / 2.0 * (real'(i) + 0.5) / real'(N));
        return 15'($rtoi(x + 0.5));
    endfunction

    logic [14:0] rom [N];
    for (genvar i = 0; i < N; i++) begin : g_rom
        assign rom[i] = rom_val(i);
    end

    logic adv;
    logic v1, v2, v3, v4;
    logic [PHASE_BITS-1:0] ph1;
    logic [1:0] q1, q2;
    logic [LUT_ADDR_BITS-1:0] a1, addr1;
    logic [14:0] rom2;
    logic signed [15:0] s3;
    logic signed [30:0] p4;
    logic [13:0] amp1, amp2, amp3;
    logic [15:0] off1, off2, off3, off4;
    logic signed [18:0] sum5;
    logic [15:0] y5;
    logic unused_phase_msbs;

    assign adv = ~m_valid | m_ready;
    assign s_ready = adv;
    assign unused_phase_msbs = ^phase_in[15:PHASE_BITS];

    // ~a is N-1-a: odd quadrants read the table backwards
    always_comb begin
        q1 = ph1[PHASE_BITS-1 -: 2];
        a1 = ph1[LUT_ADDR_BITS-1:0];
        addr1 = q1[0] ? ~a1 : a1;
        sum5 = $signed({p4[30], p4[30:13]}) + $signed({{3{off4[15]}}, off4});
        y5 = sum5 > 19'sd32767 ? 16'h7fff : sum5 < -19'sd32768 ? 16'h8000 : sum5[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            v4 <= 1'b0;
            m_valid <= 1'b0;
            m_data <= 16'h0000;
        end else if (adv) begin
            v1 <= s_valid;
            ph1 <= phase_in[PHASE_BITS-1:0];
            amp1 <= amp_in;
            off1 <= offset_in;
            v2 <= v1;
            q2 <= q1;
            rom2 <= rom[addr1];
            amp2 <= amp1;
            off2 <= off1;
            v3 <= v2;
            s3 <= q2[1] ? -$signed({1'b0, rom2}) : $signed({1'b0, rom2});
            amp3 <= amp2;
            off3 <= off2;
            v4 <= v3;
            p4 <= $signed({{15{s3[15]}}, s3}) * $signed({17'b0, amp3});
            off4 <= off3;
            m_valid <= v4;
            if (v4) m_data <= {y5[15] ^ OUT_OFFSET_BINARY, y5[14:0]};
        end
    end
endmodule

// File: tb/tb_phase_to_amp.sv
// tb_phase_to_amp: scoreboard bench, two's-complement and offset-binary instances in lockstep
module tb_phase_to_amp;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0, reset = 1'b1, s_valid = 1'b0, m_ready = 1'b0;
    logic s_ready, s_ready_b, m_valid, m_valid_b;
    logic [15:0] phase_in = 16'h0, offset_in = 16'h0, m_data, m_data_b;
    logic [13:0] amp_in = 14'h0;
    int errors = 0, checks = 0;
    logic [15:0] exp_q [$];
    logic acc = 1'b0, stalled = 1'b0;
    logic [15:0] held = 16'h0;
    logic [15:0] b_ph [8], b_off [8], b_exp [8];
    logic [13:0] b_amp [8];
    logic [15:0] r_ph, r_off;
    logic [13:0] r_amp;
    int n_acc, t_cyc;

    always #5 clk = ~clk;

    phase_to_amp dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .phase_in(phase_in), .amp_in(amp_in), .offset_in(offset_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    phase_to_amp #(.OUT_OFFSET_BINARY(1'b1)) dut_b (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_b),
        .phase_in(phase_in), .amp_in(amp_in), .offset_in(offset_in),
        .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b)
    );

    // Full-wave sine of the phase-cell centre, scaled, floored, offset, clamped
    function automatic logic [15:0] ref_model(input logic [15:0] ph, input logic [13:0] amp, input logic [15:0] off);
        real x;
        longint s, a, p, y;
        x = 32767.0 * $sin(2.0 * PI * (real'(ph[13:0]) + 0.5) / 16384.0);
        s = x >= 0.0 ? longint'($rtoi(x + 0.5)) : -longint'($rtoi(0.5 - x));
        a = longint'(amp);
        p = s * a;
        y = longint'($rtoi($floor(real'(p) / 8192.0))) + longint'($signed(off));
        y = y > 32767 ? 32767 : y < -32768 ? -32768 : y;
        return 16'(y);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic cyc(input logic sv, input logic [15:0] ph, input logic [13:0] amp,
                       input logic [15:0] off, input logic mr, input logic [15:0] e);
        @(negedge clk);
        s_valid = sv;
        phase_in = ph;
        amp_in = amp;
        offset_in = off;
        m_ready = mr;
        #1;
        acc = sv && s_ready && !reset;
        if (acc) exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 16'h0, 14'h0, 16'h0, 1'b1, 16'h0);
    endtask

    task automatic set_b(input int i, input logic [15:0] ph, input logic [13:0] amp,
                         input logic [15:0] off, input logic [15:0] e);
        b_ph[i] = ph;
        b_amp[i] = amp;
        b_off[i] = off;
        b_exp[i] = e;
    endtask

    // Back-to-back burst into an empty pipeline; pins latency and gap-free output
    task automatic burst(input int n, input string name);
        for (int i = 0; i <= n + 5; i++) begin
            if (i < n) cyc(1'b1, b_ph[i], b_amp[i], b_off[i], 1'b1, b_exp[i]);
            else idle(1);
            if (i > 0) check(name, 32'(m_valid), 32'(i >= 5 && i < n + 5));
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        exp_q.delete();
        repeat (n) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_m_valid", 32'(m_valid), 32'(0));
        check("reset_m_data", 32'(m_data), 32'(0));
        check("reset_m_data_b", 32'(m_data_b), 32'(0));
        check("reset_s_ready", 32'(s_ready), 32'(1));
    endtask

    task automatic drain(input string name);
        idle(12);
        check(name, 32'(exp_q.size()), 32'(0));
    endtask

    always @(negedge clk) begin : monitor
        logic [15:0] e;
        #2;
        if (reset) stalled = 1'b0;
        else begin
            if (stalled) begin
                check("hold_valid", 32'(m_valid), 32'(1));
                check("hold_data", 32'(m_data), 32'(held));
            end
            if (m_valid && !m_ready) check("stall_s_ready", 32'(s_ready), 32'(0));
            check("lockstep_valid", 32'(m_valid_b), 32'(m_valid));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("spurious_output", 32'(exp_q.size()), 32'(1));
                else begin
                    e = exp_q.pop_front();
                    check("data", 32'(m_data), 32'(e));
                    check("data_offset_binary", 32'(m_data_b), 32'(e ^ 16'h8000));
                end
            end
            stalled = m_valid && !m_ready;
            held = m_data;
        end
    end

    initial begin
        do_reset(3);

        set_b(0, 16'h0000, 14'h2000, 16'h0000, 16'h0006);
        set_b(1, 16'h1000, 14'h2000, 16'h0000, 16'h7fff);
        set_b(2, 16'h2000, 14'h2000, 16'h0000, 16'hfffa);
        set_b(3, 16'h3000, 14'h2000, 16'h0000, 16'h8001);
        burst(4, "basic_valid");
        drain("basic_drain");

        set_b(0, 16'h1000, 14'h3fff, 16'h0000, 16'h7fff);
        set_b(1, 16'h3000, 14'h3fff, 16'h0000, 16'h8000);
        set_b(2, 16'h1000, 14'h2000, 16'h0010, 16'h7fff);
        burst(3, "sat_valid");
        drain("sat_drain");

        set_b(0, 16'h2a5c, 14'h0000, 16'h1234, 16'h1234);
        set_b(1, 16'h3000, 14'h2000, 16'h0000, 16'h8001);
        set_b(2, 16'h3fff, 14'h2000, 16'h0000, 16'hfffa);
        set_b(3, 16'h0000, 14'h2000, 16'h0000, 16'h0006);
        set_b(4, 16'hc000, 14'h2000, 16'h0000, 16'h0006);
        set_b(5, 16'h1fff, 14'h2000, 16'h0000, 16'h0006);
        set_b(6, 16'h2000, 14'h0800, 16'h0000, 16'hfffe);
        set_b(7, 16'h0fff, 14'h2000, 16'hffff, 16'h7ffe);
        burst(8, "edge_valid");
        drain("edge_drain");

        n_acc = 0;
        t_cyc = 0;
        while (n_acc < 8 && t_cyc < 40) begin
            r_ph = 16'(n_acc * 16'h0800 + 16'h0123);
            cyc(1'b1, r_ph, 14'h2000, 16'h0000, !(t_cyc >= 5 && t_cyc <= 7), ref_model(r_ph, 14'h2000, 16'h0000));
            if (t_cyc >= 5 && t_cyc <= 7) check("bp_s_ready", 32'(s_ready), 32'(0));
            if (acc) n_acc++;
            t_cyc++;
        end
        check("bp_accepted", 32'(n_acc), 32'(8));
        drain("bp_drain");

        for (int i = 0; i < 4; i++) cyc(1'b1, 16'(i * 16'h1000), 14'h2000, 16'h0000, 1'b1, 16'h0);
        do_reset(1);
        idle(8);
        check("post_reset_empty", 32'(exp_q.size()), 32'(0));
        set_b(0, 16'h1000, 14'h1000, 16'h0000, 16'h3fff);
        burst(1, "post_reset_latency");
        drain("post_reset_drain");

        n_acc = 0;
        t_cyc = 0;
        while (n_acc < 10000 && t_cyc < 60000) begin
            r_ph = 16'($urandom);
            case ($urandom_range(0, 9))
                0: r_ph[11:0] = 12'h000;
                1: r_ph[11:0] = 12'hfff;
                default: ;
            endcase
            r_amp = 14'($urandom);
            r_off = $urandom_range(0, 1) == 1 ? 16'($urandom) : 16'($urandom_range(0, 511)) - 16'd256;
            cyc($urandom_range(0, 3) != 0, r_ph, r_amp, r_off, $urandom_range(0, 3) != 0, ref_model(r_ph, r_amp, r_off));
            if (acc) n_acc++;
            t_cyc++;
        end
        check("sweep_accepted", 32'(n_acc), 32'(10000));
        drain("sweep_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
